pkt_buf_addr_mgmt: RTL and testbench
====================================

Name: pkt_buf_addr_mgmt

Overview:
- Address initiator for the 2048x134 packet data buffer; drives the write-base and read-base address interface of the data buffer controller.
- Allocates fixed-size buffer slots to packets arriving from ibm and releases them once the packet has been fully read out to ebm.
- Keeps a free-slot list and an in-order transmit queue, and reports occupancy and drop statistics.

Parameters:
- SLOT_AW, 4, log2 of the slot count. There are 16 slots.
- LINE_AW, 7, log2 of the lines per slot. Each slot is 128 lines of 134 bits. SLOT_AW+LINE_AW must equal 11.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_pkt_req  in  1  level from ibm requesting a buffer slot; held until out_pkt_ack or out_pkt_nack
- out_pkt_ack  out  1  one-cycle pulse: slot granted, ibm may send the packet
- out_pkt_nack  out  1  one-cycle pulse: no free slot, ibm drops the packet
- in_data_ctrl_data  in  134  packet data snooped from ibm; bits [133:132] are the header/tail tag, 2'b10 = tail
- in_data_ctrl_data_wr  in  1  data valid
- addr2data_waddr  out  11  write base address = {slot, LINE_AW'b0}
- addr2data_waddr_wr  out  1  one-cycle pulse qualifying addr2data_waddr
- in_ebm_rdy  in  1  level: ebm can accept a new packet
- addr2data_raddr  out  11  read base address = {slot, LINE_AW'b0}
- addr2data_raddr_wr  out  1  one-cycle pulse qualifying addr2data_raddr
- in_data_cache_valid_wr  in  1  end-of-packet pulse from the data buffer controller's read side
- out_init_done  out  1  high once the free list has been initialised
- out_free_cnt  out  SLOT_AW+1  number of free slots
- out_queue_cnt  out  SLOT_AW+1  number of packets queued for transmit
- out_drop_cnt  out  16  count of nacked requests; saturates at 16'hFFFF

Behaviour:
- Reset:
  - All outputs are 0, both FSMs go to their INIT/IDLE states, and both lists are emptied.
  - Reset asserted mid-operation abandons any in-flight packet; all slots are reclaimed by re-initialisation.
- Free list: register FIFO of 2^SLOT_AW entries, SLOT_AW bits each.
- Transmit queue: register FIFO of the same size, in order.
- Slots are conserved, so neither FIFO can overflow. A push and a pop in the same cycle are both honoured and leave the count unchanged.
- Write FSM states are W_INIT, W_IDLE and W_WAIT_TAIL.
- W_INIT:
  - Pushes slot indices 0..2^SLOT_AW-1 into the free list, one per cycle.
  - After 16 cycles, out_init_done goes high and the FSM moves to W_IDLE.
  - in_pkt_req is ignored in this state.
- W_IDLE with in_pkt_req high and free list non-empty:
  - Pops one slot.
  - Next cycle: addr2data_waddr = {slot,0} and addr2data_waddr_wr = 1 for one cycle; out_pkt_ack = 1 in the same cycle.
  - Moves to W_WAIT_TAIL.
- W_IDLE with in_pkt_req high and free list empty:
  - out_pkt_nack = 1 for one cycle and out_drop_cnt increments (saturating).
  - Stays in W_IDLE. The request is not re-evaluated until in_pkt_req has been low for at least one cycle.
- W_WAIT_TAIL:
  - On in_data_ctrl_data_wr=1 with in_data_ctrl_data[133:132]==2'b10, pushes the held slot to the transmit queue and returns to W_IDLE.
  - in_pkt_req is ignored in this state.
- Read FSM states are R_IDLE and R_BUSY.
- R_IDLE:
  - If the transmit queue is non-empty and in_ebm_rdy=1, pops the head slot.
  - Next cycle: addr2data_raddr = {slot,0} and addr2data_raddr_wr = 1 for one cycle.
  - Moves to R_BUSY.
- R_BUSY:
  - On in_data_cache_valid_wr=1, pushes the slot back to the free list and returns to R_IDLE.
  - A slot cannot be re-read before it has been freed.
- The read and write FSMs run concurrently. A free-list push from the read side and a pop from the write side in the same cycle are legal.
- addr2data_waddr and addr2data_raddr hold their last value between pulses.
- Counters update on the clock edge after the FIFO operation.

Test Plan:
- Reset release -> out_init_done rises exactly 16 cycles later; out_free_cnt=16, out_queue_cnt=0, all pulses 0.
- One req, then a 4-line packet with tail, in_ebm_rdy=1 -> out_pkt_ack and waddr_wr with waddr=0x000; queue_cnt=1; raddr_wr with raddr=0x000. After valid_wr pulse, free_cnt returns to 16.
- 17 back-to-back packets with in_ebm_rdy=0 -> 16 acks with waddr 0x000,0x080,...,0x780. The 17th request gets nack; drop_cnt=1, free_cnt=0, queue_cnt=16.
- From the full state, assert in_ebm_rdy -> raddr_wr pulses in order 0x000,0x080,... each following the prior valid_wr. The next write ack reuses slot 0 (waddr=0x000).
- Same-cycle valid_wr (freeing slot 3) and an allocation pop with free_cnt=1 -> free_cnt=1 afterwards, no corruption; the next allocation returns slot 3.
- rst_n low for 1 cycle while in W_WAIT_TAIL and R_BUSY -> after re-init, free_cnt=16, queue_cnt=0, drop_cnt=0, and no spurious pulses.

Source files
------------

// File: rtl/pkt_buf_addr_mgmt.sv
// Packet buffer address manager. Hands out fixed-size slots of the
// 2048x134 data buffer to packets arriving from ibm. It queues filled slots
// for transmit in arrival order and returns each slot to the free list once
// ebm has finished reading it.
module pkt_buf_addr_mgmt #(
  parameter int SLOT_AW = 4,
  parameter int LINE_AW = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_pkt_req,
  output logic                       out_pkt_ack,
  output logic                       out_pkt_nack,
  input  logic [133:0]               in_data_ctrl_data,
  input  logic                       in_data_ctrl_data_wr,
  output logic [SLOT_AW+LINE_AW-1:0] addr2data_waddr,
  output logic                       addr2data_waddr_wr,
  input  logic                       in_ebm_rdy,
  output logic [SLOT_AW+LINE_AW-1:0] addr2data_raddr,
  output logic                       addr2data_raddr_wr,
  input  logic                       in_data_cache_valid_wr,
  output logic                       out_init_done,
  output logic [SLOT_AW:0]           out_free_cnt,
  output logic [SLOT_AW:0]           out_queue_cnt,
  output logic [15:0]                out_drop_cnt
);

  localparam int NSLOT = 1 << SLOT_AW;
  localparam int AW    = SLOT_AW + LINE_AW;
  localparam int CW    = SLOT_AW + 1;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_WAIT_TAIL} w_state_e;
  typedef enum logic       {R_IDLE, R_BUSY}              r_state_e;

  // Only the header/tail tag of the snooped data matters here.
  logic unused_data;
  assign unused_data = ^in_data_ctrl_data[131:0];

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [SLOT_AW-1:0]  init_idx_q, init_idx_d;
  logic                init_done_q, init_done_d;
  logic [SLOT_AW-1:0]  wslot_q, wslot_d;
  logic [SLOT_AW-1:0]  rslot_q, rslot_d;
  logic [AW-1:0]       waddr_q, waddr_d, raddr_q, raddr_d;
  logic                waddr_wr_q, waddr_wr_d, raddr_wr_q, raddr_wr_d;
  logic                ack_q, ack_d, nack_q, nack_d;
  logic                req_blk_q, req_blk_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  // Free list and transmit queue: circular register FIFOs.
  logic [SLOT_AW-1:0]  free_mem_q [NSLOT];
  logic [SLOT_AW-1:0]  tx_mem_q   [NSLOT];
  logic [SLOT_AW-1:0]  free_wp_q, free_wp_d, free_rp_q, free_rp_d;
  logic [SLOT_AW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]       free_cnt_q, free_cnt_d, tx_cnt_q, tx_cnt_d;

  logic                init_push, rd_free_push, free_push, free_pop;
  logic                tx_push, tx_pop;
  logic [SLOT_AW-1:0]  free_push_slot, free_head, tx_head;

  assign free_head = free_mem_q[free_rp_q];
  assign tx_head   = tx_mem_q[tx_rp_q];

  // Write side: seed the free list, then grant slots and wait for each tail.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_d   = w_state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    wslot_d     = wslot_q;
    waddr_d     = waddr_q;
    waddr_wr_d  = 1'b0;
    ack_d       = 1'b0;
    nack_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    req_blk_d   = req_blk_q & in_pkt_req;
    init_push   = 1'b0;
    free_pop    = 1'b0;
    tx_push     = 1'b0;
    case (w_state_q)
      W_INIT: begin
        init_push  = 1'b1;
        init_idx_d = init_idx_q + SLOT_AW'(1);
        if (init_idx_q == '1) begin
          init_done_d = 1'b1;
          w_state_d   = W_IDLE;
        end
      end
      W_IDLE: begin
        if (in_pkt_req && !req_blk_q) begin
          if (free_cnt_q != '0) begin
            free_pop   = 1'b1;
            wslot_d    = free_head;
            waddr_d    = {free_head, {LINE_AW{1'b0}}};
            waddr_wr_d = 1'b1;
            ack_d      = 1'b1;
            w_state_d  = W_WAIT_TAIL;
          end else begin
            // Refused requests stay blocked until ibm drops in_pkt_req.
            nack_d    = 1'b1;
            req_blk_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      W_WAIT_TAIL: begin
        if (in_data_ctrl_data_wr && in_data_ctrl_data[133:132] == TAG_TAIL) begin
          tx_push   = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_INIT;
    endcase
  end

  // Read side: launch the oldest queued packet, free its slot at end of read.
  always_comb begin
    r_state_d    = r_state_q;
    rslot_d      = rslot_q;
    raddr_d      = raddr_q;
    raddr_wr_d   = 1'b0;
    tx_pop       = 1'b0;
    rd_free_push = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (tx_cnt_q != '0 && in_ebm_rdy) begin
          tx_pop     = 1'b1;
          rslot_d    = tx_head;
          raddr_d    = {tx_head, {LINE_AW{1'b0}}};
          raddr_wr_d = 1'b1;
          r_state_d  = R_BUSY;
        end
      end
      R_BUSY: begin
        if (in_data_cache_valid_wr) begin
          rd_free_push = 1'b1;
          r_state_d    = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FIFO bookkeeping. Seeding and read-side returns never overlap because
  // the transmit queue is empty during initialisation.
  always_comb begin
    free_push      = init_push | rd_free_push;
    free_push_slot = init_push ? init_idx_q : rslot_q;
    free_wp_d      = free_wp_q + SLOT_AW'(free_push);
    free_rp_d      = free_rp_q + SLOT_AW'(free_pop);
    free_cnt_d     = free_cnt_q + CW'(free_push) - CW'(free_pop);
    tx_wp_d        = tx_wp_q + SLOT_AW'(tx_push);
    tx_rp_d        = tx_rp_q + SLOT_AW'(tx_pop);
    tx_cnt_d       = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

  // FIFO storage.
  // NOTE: storage has no reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (free_push) free_mem_q[free_wp_q] <= free_push_slot;
    if (tx_push)   tx_mem_q[tx_wp_q]     <= wslot_q;
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      w_state_q   <= W_INIT;
      r_state_q   <= R_IDLE;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      wslot_q     <= '0;
      rslot_q     <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      waddr_wr_q  <= 1'b0;
      raddr_wr_q  <= 1'b0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      req_blk_q   <= 1'b0;
      drop_cnt_q  <= '0;
      free_wp_q   <= '0;
      free_rp_q   <= '0;
      free_cnt_q  <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      wslot_q     <= wslot_d;
      rslot_q     <= rslot_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      waddr_wr_q  <= waddr_wr_d;
      raddr_wr_q  <= raddr_wr_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      req_blk_q   <= req_blk_d;
      drop_cnt_q  <= drop_cnt_d;
      free_wp_q   <= free_wp_d;
      free_rp_q   <= free_rp_d;
      free_cnt_q  <= free_cnt_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  assign out_pkt_ack        = ack_q;
  assign out_pkt_nack       = nack_q;
  assign addr2data_waddr    = waddr_q;
  assign addr2data_waddr_wr = waddr_wr_q;
  assign addr2data_raddr    = raddr_q;
  assign addr2data_raddr_wr = raddr_wr_q;
  assign out_init_done      = init_done_q;
  assign out_free_cnt       = free_cnt_q;
  assign out_queue_cnt      = tx_cnt_q;
  assign out_drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_pkt_buf_addr_mgmt.sv
// Self-checking bench for pkt_buf_addr_mgmt. The reference model tracks
// slots as plain queues: the free list, the transmit order and a drop count.
module tb_pkt_buf_addr_mgmt;

  localparam int SLOT_AW = 4;
  localparam int LINE_AW = 7;
  localparam int NSLOT   = 1 << SLOT_AW;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_pkt_req;
  logic                       out_pkt_ack;
  logic                       out_pkt_nack;
  logic [133:0]               in_data_ctrl_data;
  logic                       in_data_ctrl_data_wr;
  logic [SLOT_AW+LINE_AW-1:0] addr2data_waddr;
  logic                       addr2data_waddr_wr;
  logic                       in_ebm_rdy;
  logic [SLOT_AW+LINE_AW-1:0] addr2data_raddr;
  logic                       addr2data_raddr_wr;
  logic                       in_data_cache_valid_wr;
  logic                       out_init_done;
  logic [SLOT_AW:0]           out_free_cnt;
  logic [SLOT_AW:0]           out_queue_cnt;
  logic [15:0]                out_drop_cnt;

  always #5 clk = ~clk;

  pkt_buf_addr_mgmt #(.SLOT_AW(SLOT_AW), .LINE_AW(LINE_AW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_pkt_req             (in_pkt_req),
    .out_pkt_ack            (out_pkt_ack),
    .out_pkt_nack           (out_pkt_nack),
    .in_data_ctrl_data      (in_data_ctrl_data),
    .in_data_ctrl_data_wr   (in_data_ctrl_data_wr),
    .addr2data_waddr        (addr2data_waddr),
    .addr2data_waddr_wr     (addr2data_waddr_wr),
    .in_ebm_rdy             (in_ebm_rdy),
    .addr2data_raddr        (addr2data_raddr),
    .addr2data_raddr_wr     (addr2data_raddr_wr),
    .in_data_cache_valid_wr (in_data_cache_valid_wr),
    .out_init_done          (out_init_done),
    .out_free_cnt           (out_free_cnt),
    .out_queue_cnt          (out_queue_cnt),
    .out_drop_cnt           (out_drop_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  int unsigned free_q[$];
  int unsigned tx_q[$];
  int          drop_m;
  int unsigned busy_slot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] mk_line(input logic [1:0] tag);
    logic [133:0] d;
    d = {6'($urandom), $urandom, $urandom, $urandom, $urandom};
    d[133:132] = tag;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_free_cnt"},  32'(out_free_cnt),  32'(free_q.size()));
    check({tag, "_queue_cnt"}, 32'(out_queue_cnt), 32'(tx_q.size()));
    check({tag, "_drop_cnt"},  32'(out_drop_cnt),  32'(drop_m));
  endtask

  // Reset, check the cleared outputs, then time the free-list initialisation.
  task automatic do_reset(input int low_cycles);
    int lat;
    rst_n = 1'b0;
    in_data_ctrl_data_wr   = 1'b0;
    in_data_cache_valid_wr = 1'b0;
    for (int i = 0; i < low_cycles; i++) tick();
    check("rst_pulses", 32'({out_pkt_ack, out_pkt_nack, addr2data_waddr_wr,
                             addr2data_raddr_wr, out_init_done}), 32'd0);
    check("rst_addrs", 32'({addr2data_waddr, addr2data_raddr}), 32'd0);
    check("rst_cnts", 32'({out_free_cnt, out_queue_cnt, out_drop_cnt}), 32'd0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("init_no_pulse", 32'({out_pkt_ack, out_pkt_nack, addr2data_waddr_wr,
                                  addr2data_raddr_wr}), 32'd0);
      if (out_init_done) begin
        lat = i;
        break;
      end
    end
    in_pkt_req = 1'b0;
    check("init_latency", 32'(lat), 32'd16);
    free_q.delete();
    tx_q.delete();
    for (int s = 0; s < NSLOT; s++) free_q.push_back(s);
    drop_m = 0;
    check_counts("after_init");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_init_quiet", 32'({out_pkt_ack, out_pkt_nack, addr2data_waddr_wr,
                                    addr2data_raddr_wr}), 32'd0);
    end
  endtask

  // Request a slot and compare the grant or refusal with the model.
  task automatic alloc(input bit hold, output bit acked, output int unsigned slot);
    bit exp_ack;
    bit seen;
    exp_ack = (free_q.size() != 0);
    seen    = 1'b0;
    acked   = 1'b0;
    slot    = 0;
    in_pkt_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_pkt_ack || out_pkt_nack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!hold) in_pkt_req = 1'b0;
    check("req_answered", 32'(seen), 32'd1);
    if (seen) begin
      check("ack",  32'(out_pkt_ack),  32'(exp_ack));
      check("nack", 32'(out_pkt_nack), 32'(!exp_ack));
      if (exp_ack) begin
        slot  = free_q.pop_front();
        acked = 1'b1;
        check("waddr_wr", 32'(addr2data_waddr_wr), 32'd1);
        check("waddr", 32'(addr2data_waddr), slot << LINE_AW);
      end else begin
        if (drop_m < 65535) drop_m++;
        check("drop_cnt", 32'(out_drop_cnt), 32'(drop_m));
      end
      check("alloc_free_cnt", 32'(out_free_cnt), 32'(free_q.size()));
    end
  endtask

  // Stream one packet; a tail-tagged idle cycle first shows data_wr qualifies the tag.
  task automatic send_pkt(input int unsigned slot, input int lines);
    in_data_ctrl_data    = mk_line(2'b10);
    in_data_ctrl_data_wr = 1'b0;
    tick();
    for (int i = 0; i < lines; i++) begin
      in_data_ctrl_data    = mk_line((i == lines - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b00));
      in_data_ctrl_data_wr = 1'b1;
      tick();
    end
    in_data_ctrl_data_wr = 1'b0;
    tx_q.push_back(slot);
    check("send_queue_cnt", 32'(out_queue_cnt), 32'(tx_q.size()));
  endtask

  task automatic wait_raddr();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (addr2data_raddr_wr) begin
        seen = 1'b1;
        break;
      end
    end
    check("raddr_wr_seen", 32'(seen), 32'd1);
    if (seen && tx_q.size() != 0) begin
      busy_slot = tx_q.pop_front();
      check("raddr", 32'(addr2data_raddr), busy_slot << LINE_AW);
    end
  endtask

  task automatic finish_read(input int gap);
    for (int i = 0; i < gap; i++) begin
      tick();
      check("no_reread", 32'(addr2data_raddr_wr), 32'd0);
    end
    in_data_cache_valid_wr = 1'b1;
    tick();
    in_data_cache_valid_wr = 1'b0;
    free_q.push_back(busy_slot);
    check("freed_cnt", 32'(out_free_cnt), 32'(free_q.size()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acked;
    int unsigned slot;
    int unsigned exp_slot;

    rst_n = 1'b0;
    in_pkt_req = 1'b0;
    in_data_ctrl_data = '0;
    in_data_ctrl_data_wr = 1'b0;
    in_ebm_rdy = 1'b0;
    in_data_cache_valid_wr = 1'b0;
    drop_m = 0;
    busy_slot = 0;

    // Power-on reset and initialisation timing.
    do_reset(2);

    // Single packet end to end with ebm ready.
    in_ebm_rdy = 1'b1;
    alloc(1'b0, acked, slot);
    if (acked) send_pkt(slot, 4);
    wait_raddr();
    finish_read(2);
    check_counts("single_pkt");
    in_ebm_rdy = 1'b0;

    // Fresh free list, then fill every slot; the 17th request is refused.
    do_reset(1);
    for (int p = 0; p < NSLOT + 1; p++) begin
      alloc(1'b0, acked, slot);
      if (acked) send_pkt(slot, $urandom_range(1, 8));
      tick();
    end
    check_counts("full");

    // Drain the first three in order, leave the read side busy on the fourth.
    in_ebm_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_raddr();
      finish_read($urandom_range(0, 3));
    end
    wait_raddr();
    in_ebm_rdy = 1'b0;

    // Reallocate freed slots in order until exactly one is free.
    for (int p = 0; p < 2; p++) begin
      alloc(1'b0, acked, slot);
      if (acked) send_pkt(slot, $urandom_range(1, 4));
    end
    check_counts("one_free");

    // Read-side release and write-side grant on the same edge.
    in_pkt_req = 1'b1;
    in_data_cache_valid_wr = 1'b1;
    tick();
    in_pkt_req = 1'b0;
    in_data_cache_valid_wr = 1'b0;
    check("same_cycle_ack", 32'(out_pkt_ack), 32'd1);
    exp_slot = free_q.pop_front();
    free_q.push_back(busy_slot);
    check("same_cycle_waddr", 32'(addr2data_waddr), exp_slot << LINE_AW);
    check("same_cycle_free_cnt", 32'(out_free_cnt), 32'(free_q.size()));
    send_pkt(exp_slot, 3);
    alloc(1'b0, acked, slot);
    if (acked) send_pkt(slot, 2);
    check_counts("reused");

    // Refused request held high stays refused even after a slot frees up.
    alloc(1'b1, acked, slot);
    in_ebm_rdy = 1'b1;
    wait_raddr();
    in_ebm_rdy = 1'b0;
    finish_read(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_req_blocked", 32'({out_pkt_ack, out_pkt_nack}), 32'd0);
    end
    in_pkt_req = 1'b0;
    tick();
    alloc(1'b0, acked, slot);

    // Reset while the write side waits for a tail and the read side is busy.
    in_ebm_rdy = 1'b1;
    wait_raddr();
    in_pkt_req = 1'b1;
    do_reset(1);
    in_ebm_rdy = 1'b0;

    // Random mix of allocations and reads against the model.
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op != 0 || tx_q.size() == 0) begin
        alloc(1'b0, acked, slot);
        if (acked) send_pkt(slot, $urandom_range(1, 6));
      end else begin
        in_ebm_rdy = 1'b1;
        wait_raddr();
        in_ebm_rdy = 1'b0;
        finish_read($urandom_range(0, 3));
      end
      check_counts("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
